// File: rtl/fetch_pkg.sv
// ============================================================================
// Module      : fetch_pkg
// Description : Shared state encoding, boot default and counter sizing helper
//               for the fetch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_MDWAIT = 2'd2,
        ST_REDIR  = 2'd3
    } fsm_state_e;

    localparam int c_boot_cycles_def = 2;
    // BOOT_CYCLES may be as large as 15, so the shared counter never drops below 4 bits.
    localparam int c_boot_cnt_w      = 4;

    function automatic int ctr_width(input int mdlat_w);
        return (mdlat_w > c_boot_cnt_w) ? mdlat_w : c_boot_cnt_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dff.sv
// ============================================================================
// Module      : dff
// Description : Generic register cell with asynchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_o <= RST_VAL;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    dff #(
        .WIDTH   (WIDTH),
        .RST_VAL ('0)
    ) u_count (
        .clk (clk),
        .rst (rst),
        .d_i (count_d),
        .q_o (count_q)
    );

    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module      : fetch_sequencer
// Description : Pipeline front-end control: boot flush, hazard stalls,
//               branch/jump redirect and multi-cycle mul/div stalls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int BOOT_CYCLES = c_boot_cycles_def,
    parameter int MDLAT_W     = 5,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               LoadUse_ID,
    input  logic               MemBusy_MEM,
    input  logic               Jump_ID,
    input  logic               BranchTaken_EX,
    input  logic               MulDivStart_EX,
    input  logic [MDLAT_W-1:0] MulDivLat_EX,
    output logic               AnyStall,
    output logic               FetchFlush,
    output logic               Flush_ID,
    output logic               Bubble_EX,
    output logic               MdBusy,
    output logic [CNT_W-1:0]   StallCnt
);

    localparam int c_ctr_w = ctr_width(MDLAT_W);

    fsm_state_e         state_q;
    logic [c_ctr_w-1:0] ctr_q;
    logic               jflush_d;
    logic               jflush_q;
    logic               w_md_go;

    // A zero-latency mul/div needs no stall and never leaves RUN.
    assign w_md_go = MulDivStart_EX && (MulDivLat_EX != '0);

    always_comb begin
        AnyStall   = 1'b0;
        FetchFlush = 1'b0;
        Flush_ID   = 1'b0;
        Bubble_EX  = 1'b0;
        MdBusy     = 1'b0;
        jflush_d   = 1'b0;
        unique case (state_q)
            ST_BOOT: begin
                AnyStall   = 1'b1;
                FetchFlush = 1'b1;
                Flush_ID   = 1'b1;
                Bubble_EX  = 1'b1;
            end
            ST_RUN: begin
                AnyStall  = LoadUse_ID | MemBusy_MEM;
                Bubble_EX = LoadUse_ID & ~MemBusy_MEM;
                Flush_ID  = jflush_q;
                if (BranchTaken_EX) begin
                    AnyStall  = 1'b0;
                    Flush_ID  = 1'b1;
                    Bubble_EX = 1'b1;
                end else if (!w_md_go) begin
                    jflush_d = Jump_ID;
                end
            end
            ST_MDWAIT: begin
                AnyStall  = 1'b1;
                Bubble_EX = 1'b1;
                MdBusy    = 1'b1;
            end
            ST_REDIR: begin
                Flush_ID  = 1'b1;
                Bubble_EX = BranchTaken_EX;
            end
            default: begin
                AnyStall = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_BOOT;
            ctr_q   <= c_ctr_w'(BOOT_CYCLES);
        end else begin
            unique case (state_q)
                ST_BOOT: begin
                    ctr_q <= ctr_q - c_ctr_w'(1);
                    if (ctr_q == c_ctr_w'(1)) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN, ST_REDIR: begin
                    if (BranchTaken_EX) begin
                        state_q <= ST_REDIR;
                    end else if ((state_q == ST_RUN) && w_md_go) begin
                        state_q <= ST_MDWAIT;
                        ctr_q   <= c_ctr_w'(MulDivLat_EX);
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_MDWAIT: begin
                    if (ctr_q == c_ctr_w'(1)) begin
                        state_q <= ST_RUN;
                    end else begin
                        ctr_q <= ctr_q - c_ctr_w'(1);
                    end
                end
                default: begin
                    state_q <= ST_BOOT;
                end
            endcase
        end
    end

    dff #(
        .WIDTH   (1),
        .RST_VAL (1'b0)
    ) u_jflush (
        .clk (clk),
        .rst (reset),
        .d_i (jflush_d),
        .q_o (jflush_q)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst     (reset),
        .inc_i   (AnyStall),
        .count_o (StallCnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Directed table-driven bench for fetch_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fetch_sequencer;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       lu    = 1'b0;
    logic       mb    = 1'b0;
    logic       jmp   = 1'b0;
    logic       br    = 1'b0;
    logic       mds   = 1'b0;
    logic [4:0] lat   = 5'd0;

    logic        as1, ff1, fid1, bex1, mdb1;
    logic [15:0] cnt1;
    logic        as2, ff2, fid2, bex2, mdb2;
    logic [3:0]  cnt2;

    always #5 clk = ~clk;

    fetch_sequencer u_dut (
        .clk            (clk),
        .reset          (reset),
        .LoadUse_ID     (lu),
        .MemBusy_MEM    (mb),
        .Jump_ID        (jmp),
        .BranchTaken_EX (br),
        .MulDivStart_EX (mds),
        .MulDivLat_EX   (lat),
        .AnyStall       (as1),
        .FetchFlush     (ff1),
        .Flush_ID       (fid1),
        .Bubble_EX      (bex1),
        .MdBusy         (mdb1),
        .StallCnt       (cnt1)
    );

    fetch_sequencer #(.CNT_W(4)) u_dut_w4 (
        .clk            (clk),
        .reset          (reset),
        .LoadUse_ID     (lu),
        .MemBusy_MEM    (mb),
        .Jump_ID        (jmp),
        .BranchTaken_EX (br),
        .MulDivStart_EX (mds),
        .MulDivLat_EX   (lat),
        .AnyStall       (as2),
        .FetchFlush     (ff2),
        .Flush_ID       (fid2),
        .Bubble_EX      (bex2),
        .MdBusy         (mdb2),
        .StallCnt       (cnt2)
    );

    // Inputs packed as {LoadUse, MemBusy, Jump, Branch, MulDivStart};
    // outputs as {AnyStall, FetchFlush, Flush_ID, Bubble_EX, MdBusy}.
    typedef struct {
        logic [4:0] in_bits;
        logic [4:0] lat;
        logic [4:0] exp;
    } vec_t;

    localparam int NVEC = 18;
    vec_t tbl[NVEC];
    int   n_vec   = 0;
    int   n_err   = 0;
    int   exp_cnt = 0;

    function automatic vec_t mk(input logic [4:0] i, input logic [4:0] l, input logic [4:0] e);
        vec_t v;
        v.in_bits = i;
        v.lat     = l;
        v.exp     = e;
        return v;
    endfunction

    function automatic logic [4:0] outs1();
        return {as1, ff1, fid1, bex1, mdb1};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        {lu, mb, jmp, br, mds} = 5'b0;
        lat = 5'd0;
    endtask

    task automatic boot_wait(input string tag);
        int n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!ff1) break;
            n++;
            cyc();
        end
        chk({tag, "_boot_len"}, n, 2);
        chk({tag, "_run_outs"}, outs1(), 5'b00000);
        chk({tag, "_boot_cnt"}, cnt1, 2);
        chk({tag, "_boot_cnt_w4"}, cnt2, 2);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        tbl[0]  = mk(5'b00000, 5'd0, 5'b00000);
        tbl[1]  = mk(5'b10000, 5'd0, 5'b10010);
        tbl[2]  = mk(5'b11000, 5'd0, 5'b10000);
        tbl[3]  = mk(5'b01000, 5'd0, 5'b10000);
        tbl[4]  = mk(5'b00100, 5'd0, 5'b00000);
        tbl[5]  = mk(5'b00000, 5'd0, 5'b00100);
        tbl[6]  = mk(5'b00000, 5'd0, 5'b00000);
        tbl[7]  = mk(5'b10010, 5'd0, 5'b00110);
        tbl[8]  = mk(5'b00000, 5'd0, 5'b00100);
        tbl[9]  = mk(5'b00010, 5'd0, 5'b00110);
        tbl[10] = mk(5'b00010, 5'd0, 5'b00110);
        tbl[11] = mk(5'b00000, 5'd0, 5'b00100);
        tbl[12] = mk(5'b00001, 5'd0, 5'b00000);
        tbl[13] = mk(5'b00000, 5'd0, 5'b00000);
        tbl[14] = mk(5'b00001, 5'd2, 5'b00000);
        tbl[15] = mk(5'b11000, 5'd0, 5'b10011);
        tbl[16] = mk(5'b00000, 5'd0, 5'b10011);
        tbl[17] = mk(5'b00000, 5'd0, 5'b00000);

        // Reset state, then release and boot.
        clear_inputs();
        reset = 1'b1;
        repeat (2) cyc();
        @(negedge clk);
        chk("reset_outs", outs1(), 5'b11110);
        chk("reset_cnt", cnt1, 0);
        cyc();
        reset = 1'b0;
        boot_wait("a");
        exp_cnt = 2;

        // Table of single-cycle vectors starting in RUN.
        for (int i = 0; i < NVEC; i++) begin
            {lu, mb, jmp, br, mds} = tbl[i].in_bits;
            lat = tbl[i].lat;
            @(negedge clk);
            chk($sformatf("vec%0d", i), outs1(), tbl[i].exp);
            if (tbl[i].exp[4]) exp_cnt++;
            cyc();
        end
        clear_inputs();
        @(negedge clk);
        chk("table_cnt", cnt1, exp_cnt);
        cyc();

        // Mul/div with latency 3.
        begin
            int n = 0;
            mds = 1'b1;
            lat = 5'd3;
            @(negedge clk);
            chk("md_issue", outs1(), 5'b00000);
            cyc();
            clear_inputs();
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (!(as1 && mdb1)) break;
                n++;
                cyc();
            end
            exp_cnt += 3;
            chk("md_len", n, 3);
            chk("md_after", outs1(), 5'b00000);
            chk("md_cnt", cnt1, exp_cnt);
            cyc();
        end

        // Branch and mul/div start in the same cycle: branch wins.
        begin
            int nf = 0;
            int nm = 0;
            int ns = 0;
            br  = 1'b1;
            mds = 1'b1;
            lat = 5'd4;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                nf += int'(fid1);
                nm += int'(mdb1);
                ns += int'(as1);
                cyc();
                clear_inputs();
            end
            chk("brmd_flush_cycles", nf, 2);
            chk("brmd_mdbusy_cycles", nm, 0);
            chk("brmd_stall_cycles", ns, 0);
            chk("brmd_cnt", cnt1, exp_cnt);
        end

        // Reset pulsed in the second MDWAIT cycle.
        begin
            int nm = 0;
            int ns = 0;
            mds = 1'b1;
            lat = 5'd10;
            cyc();
            clear_inputs();
            cyc();
            #1;
            chk("mdrst_busy_before", mdb1, 1);
            reset = 1'b1;
            #1;
            chk("mdrst_outs", outs1(), 5'b11110);
            chk("mdrst_cnt", cnt1, 0);
            cyc();
            reset = 1'b0;
            boot_wait("e");
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                nm += int'(mdb1);
                ns += int'(as1);
                cyc();
            end
            chk("mdrst_no_mdbusy", nm, 0);
            chk("mdrst_no_stall", ns, 0);
            exp_cnt = 2;
        end

        // Saturation of the 4-bit counter over 20 stall cycles.
        reset = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
        boot_wait("f");
        lu = 1'b1;
        repeat (13) cyc();
        chk("sat_mid_w4", cnt2, 15);
        chk("sat_stall_w4", as2, 1);
        repeat (7) cyc();
        lu = 1'b0;
        exp_cnt += 20;
        @(negedge clk);
        chk("sat_hold_w4", cnt2, 15);
        chk("sat_cnt_w16", cnt1, exp_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter BOOT_CYCLES, default 2: cycles the fetch flush is held after reset release; legal range 1..15.
REQ-002 Parameter MDLAT_W, default 5: width of the multiply/divide latency input.
REQ-003 Parameter CNT_W, default 16: width of the stall performance counter.
REQ-004 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-005 Port reset  input  1: asynchronous, active-high reset.
REQ-006 Port LoadUse_ID  input  1: load-use hazard detected in decode.
REQ-007 Port MemBusy_MEM  input  1: data memory not ready this cycle.
REQ-008 Port Jump_ID  input  1: jump resolved in decode.
REQ-009 Port BranchTaken_EX  input  1: taken branch resolved in execute.
REQ-010 Port MulDivStart_EX  input  1: multi-cycle multiply/divide issues this cycle.
REQ-011 Port MulDivLat_EX  input  MDLAT_W: extra stall cycles required by that operation.
REQ-012 Port AnyStall  output  1: freeze the PC and the IF/ID registers.
REQ-013 Port FetchFlush  output  1: clears the fetch-stage registers.
REQ-014 Port Flush_ID  output  1: converts the decode-stage instruction into a NOP.
REQ-015 Port Bubble_EX  output  1: inserts a NOP into execute.
REQ-016 Port MdBusy  output  1: high while a multiply/divide stall is in progress.
REQ-017 Port StallCnt  output  CNT_W: saturating count of cycles with AnyStall=1.

Function
REQ-018 The FSM SHALL have exactly four states: BOOT, RUN, MDWAIT and REDIR.
REQ-019 In BOOT, FetchFlush, AnyStall, Flush_ID and Bubble_EX SHALL all be 1; a down-counter loaded with BOOT_CYCLES SHALL decrement each cycle, and the FSM SHALL go to RUN on the cycle the counter reaches 0.
REQ-020 In RUN, AnyStall SHALL equal LoadUse_ID | MemBusy_MEM, combinationally in the same cycle.
REQ-021 In RUN, Bubble_EX SHALL equal LoadUse_ID & ~MemBusy_MEM.
REQ-022 In RUN, if BranchTaken_EX=1:
  - Flush_ID=1 and Bubble_EX=1 in the same cycle;
  - AnyStall forced to 0;
  - next state REDIR.
REQ-023 In RUN, if Jump_ID=1 and BranchTaken_EX=0, FetchFlush SHALL be 0 and Flush_ID SHALL be 1 in the following cycle only, registered; the state SHALL stay RUN.
REQ-024 In RUN, MulDivStart_EX=1 with MulDivLat_EX=N>0 (no branch) SHALL load counter=N and move to MDWAIT; with N=0 there SHALL be no stall and the state SHALL stay RUN.
REQ-025 In MDWAIT:
  - AnyStall=1, MdBusy=1 and Bubble_EX=1;
  - the counter SHALL decrement each cycle, and the FSM SHALL return to RUN when it reaches 1, giving exactly N stall cycles.
REQ-026 In MDWAIT, MemBusy_MEM and LoadUse_ID SHALL be ignored.
REQ-027 In MDWAIT, BranchTaken_EX SHALL have no effect; the producer guarantees it is 0.
REQ-028 REDIR SHALL last one cycle: Flush_ID=1 and AnyStall=0, then RUN unconditionally. A second BranchTaken_EX in REDIR SHALL be treated as in RUN and SHALL re-enter REDIR.
REQ-029 Simultaneous events SHALL be resolved with priority BranchTaken_EX > MulDivStart_EX > Jump_ID > stall terms. A MulDivStart_EX that loses to a branch SHALL be dropped.
REQ-030 StallCnt SHALL increment by 1 on every cycle with AnyStall=1, including BOOT, and SHALL saturate at all-ones with no wrap.
REQ-031 MdBusy SHALL be 0 in every state except MDWAIT.

Reset
REQ-032 Asserting reset SHALL asynchronously force:
  - state=BOOT, counter=BOOT_CYCLES and StallCnt=0;
  - the registered jump flush cleared;
  - outputs FetchFlush=1, AnyStall=1, Flush_ID=1, Bubble_EX=1 and MdBusy=0.
REQ-033 A reset asserted mid-MDWAIT or mid-REDIR SHALL abandon the operation with no residual stall after BOOT completes.

Structure
REQ-034 State encodings (2-bit) and the BOOT_CYCLES default SHALL reside in the shared package fetch_pkg.
REQ-035 The saturating StallCnt SHALL be a sub-module sat_counter with parameter WIDTH; all other registers SHALL use the existing dff cell where feasible.

Verification
REQ-036 The bench SHALL cover reset release with BOOT_CYCLES=2: FetchFlush=1 for exactly 2 cycles after release, then RUN, and StallCnt=2.
REQ-037 The bench SHALL cover MulDivStart_EX=1 with MulDivLat_EX=3: AnyStall=1 and MdBusy=1 for exactly 3 cycles, then AnyStall=0, and StallCnt increases by 3.
REQ-038 The bench SHALL cover BranchTaken_EX=1 together with MulDivStart_EX=1 in RUN: Flush_ID=1 for 2 cycles, MdBusy never asserts, and AnyStall=0.
REQ-039 The bench SHALL cover LoadUse_ID=1 with MemBusy_MEM=1 in the same cycle: AnyStall=1 and Bubble_EX=0; with LoadUse_ID alone: AnyStall=1 and Bubble_EX=1.
REQ-040 The bench SHALL cover reset pulsed in the second cycle of MDWAIT (MulDivLat_EX=10): immediate BOOT outputs, StallCnt=0, and no MDWAIT after boot.
REQ-041 The bench SHALL cover CNT_W=4 with 20 stall cycles: StallCnt holds at 15.
